// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges the in-order pipe writeback with
// results from a small mul/div FIFO, forcing a stall when a result ages out.
module wb_arbiter #(
  parameter int W       = 32,
  parameter int R       = 5,
  parameter int DEPTH   = 2,
  parameter int AGE_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pipe_result,
  input  logic [R-1:0] pipe_rd,
  input  logic         pipe_useRd,
  input  logic         md_valid,
  input  logic [W-1:0] md_result,
  input  logic [R-1:0] md_rd,
  output logic         md_ready,
  output logic         pipe_stall,
  input  logic [R-1:0] chk_rs1,
  input  logic [R-1:0] chk_rs2,
  output logic         chk_hit,
  output logic         rf_we,
  output logic [R-1:0] rf_rd,
  output logic [W-1:0] rf_wdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [AW-1:0] AGE_MAX_C = AW'(AGE_MAX);

  logic [R-1:0]  buf_rd   [DEPTH];
  logic [W-1:0]  buf_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [AW-1:0] age;

  logic             buf_nonempty;
  logic             pipe_req;
  logic             force_head;
  logic             grant_buf;
  logic             grant_pipe;
  logic             push;
  logic [DEPTH-1:0] entry_valid;

  always_comb begin
    buf_nonempty = (count != '0);
    pipe_req     = pipe_useRd && (pipe_rd != '0);
    force_head   = buf_nonempty && (age == AGE_MAX_C);
    grant_buf    = force_head || (buf_nonempty && !pipe_req);
    grant_pipe   = pipe_req && !force_head;
    md_ready     = (count < DEPTH_C);
    push         = md_valid && md_ready && (md_rd != '0);
    pipe_stall   = force_head && pipe_req;
  end

  // An entry is live when its distance from the head is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    logic [PW-1:0] offset;
    assign offset         = PW'(g) - rd_ptr;
    assign entry_valid[g] = ({1'b0, offset} < count);
  end

  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] &&
          (((chk_rs1 != '0) && (buf_rd[i] == chk_rs1)) ||
           ((chk_rs2 != '0) && (buf_rd[i] == chk_rs2)))) begin
        chk_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      buf_rd[wr_ptr]   <= md_rd;
      buf_data[wr_ptr] <= md_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      age      <= '0;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (grant_buf) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(grant_buf);

      // Age tracks how long the current head has been waiting.
      if (!buf_nonempty || grant_buf) begin
        age <= '0;
      end else if (age != AGE_MAX_C) begin
        age <= age + AW'(1);
      end

      if (grant_buf) begin
        rf_we    <= 1'b1;
        rf_rd    <= buf_rd[rd_ptr];
        rf_wdata <= buf_data[rd_ptr];
      end else if (grant_pipe) begin
        rf_we    <= 1'b1;
        rf_rd    <= pipe_rd;
        rf_wdata <= pipe_result;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter W, default 32, data width of register-file write data.
REQ-002 Parameter R, default 5, register index width.
REQ-003 Parameter DEPTH, default 2, mul/div result buffer entries (power of two, >=2).
REQ-004 Parameter AGE_MAX, default 4, cycles a buffered result waits before forcing a pipeline stall.
REQ-005 One clock, clk; reset is synchronous and active-high, port reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 pipe_result  in  W  in-order writeback data from the MEM/WB stage.
REQ-009 pipe_rd  in  R  in-order destination register.
REQ-010 pipe_useRd  in  1  in-order writeback request.
REQ-011 md_valid  in  1  mul/div result available.
REQ-012 md_result  in  W  mul/div result data.
REQ-013 md_rd  in  R  mul/div destination register.
REQ-014 md_ready  out  1  buffer can accept a result this cycle.
REQ-015 pipe_stall  out  1  in-order writeback not taken this cycle; upstream holds and re-presents it.
REQ-016 chk_rs1, chk_rs2  in  R each  operand indices to check against pending results.
REQ-017 chk_hit  out  1  a valid buffer entry targets nonzero chk_rs1 or chk_rs2.
REQ-018 rf_we  out  1  register-file write enable (registered).
REQ-019 rf_rd  out  R  register-file write index (registered).
REQ-020 rf_wdata  out  W  register-file write data (registered).

Function
REQ-021 Requests with rd==0 are discarded: pipe request counts as absent; md push is accepted but not stored.
REQ-022 Push: md_valid & md_ready & md_rd!=0 writes {md_rd, md_result} at write pointer; pointer wraps modulo DEPTH.
REQ-023 md_ready = (count < DEPTH), from registered count only; no push at full even when a pop occurs in the same cycle.
REQ-024 Age counter: 0 when buffer empty or head popped this cycle; otherwise increments each cycle, saturating at AGE_MAX.
REQ-025 force = (count != 0) & (age == AGE_MAX).
REQ-026 Grant priority, one write per cycle: force -> buffer head; else pipe request -> pipe; else count != 0 -> buffer head; else none.
REQ-027 pipe_stall = force & pipe request (combinational); only the forced cycle stalls, and the next cycle serves the pipe.
REQ-028 Buffer-head grant pops the head; read pointer wraps modulo DEPTH; push and pop in the same cycle leave count unchanged.
REQ-029 Granted write appears on rf_we/rf_rd/rf_wdata at the next rising edge (1-cycle latency); rf_we = 0 with rf_rd, rf_wdata holding previous values when no grant.
REQ-030 chk_hit is combinational over valid entries only; index 0 never hits; an entry popped this cycle still hits.
REQ-031 Buffer order is FIFO; results for the same rd retire in arrival order.

Reset
REQ-032 On reset high at a rising edge: count, pointers, age, rf_we, rf_rd, rf_wdata = 0; buffer contents invalid; md_ready = 1, pipe_stall = 0, chk_hit = 0 next cycle.
REQ-033 Reset mid-operation discards all buffered results without writing them; a push presented in the reset cycle is dropped.

Verification
REQ-034 Pipe-only: pipe_useRd=1, rd=5, data=0xA5A5A5A5 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xA5A5A5A5; pipe_stall=0.
REQ-035 Idle-slot drain: md push rd=7, data=0x12 with pipe idle -> following cycle pops; rf_we=1, rf_rd=7, rf_wdata=0x12 one edge later; md_ready stays 1.
REQ-036 Starvation: push rd=3, then pipe requests every cycle -> age reaches 4, pipe_stall=1 for exactly one cycle, rd=3 written, then pipe resumes with its held request.
REQ-037 Full: two pushes while pipe busy -> md_ready=0; a third md_valid is not accepted; after one pop md_ready=1 the next cycle.
REQ-038 x0 and hazard: push rd=0 -> count stays 0; push rd=9 then chk_rs2=9 -> chk_hit=1 until the entry is popped; chk_rs1=0 -> no hit.
REQ-039 Reset mid-operation: buffer holding 2 entries, reset pulsed -> no rf_we for those entries, count=0, md_ready=1.
